// File: rtl/sine_quarter_dds.sv
// Phase-accumulator DDS front end driving an external quarter-wave sine ROM,
// with full-wave reconstruction (index mirroring and sign) of the returned word.
module sine_quarter_dds #(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_WIDTH = 8,
    parameter int PHASE_W   = 16,
    parameter int CNT_div   = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [PHASE_W-1:0]              freq_word,
    input  logic                            phase_load,
    input  logic [PHASE_W-1:0]              phase_init,
    output logic [$clog2(ROM_DEPTH)-1:0]    rom_addr,
    input  logic [ROM_WIDTH-1:0]            rom_data,
    output logic signed [2*ROM_WIDTH-1:0]   sample,
    output logic                            sample_valid,
    output logic [1:0]                      quadrant
);

    localparam int IDX_W = $clog2(ROM_DEPTH);
    localparam int CNT_W = (CNT_div > 1) ? $clog2(CNT_div) : 1;
    localparam int S_W   = 2 * ROM_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_div - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(ROM_DEPTH - 1);

    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      rom_addr_q, rom_addr_d;
    logic [1:0]            q1_q, q1_d;
    logic                  v1_q, v1_d;
    logic signed [S_W-1:0] sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [1:0]            quadrant_q, quadrant_d;

    logic                  tick;
    logic [1:0]            q_cur;
    logic [IDX_W-1:0]      idx_cur;
    logic [S_W-1:0]        rom_data_ext;

    assign tick         = en && (cnt_q == CNT_LAST);
    assign q_cur        = phase_q[PHASE_W-1 -: 2];
    assign idx_cur      = phase_q[PHASE_W-3 -: IDX_W];
    assign rom_data_ext = {{ROM_WIDTH{1'b0}}, rom_data};

    always_comb begin
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        rom_addr_d     = rom_addr_q;
        q1_d           = q1_q;
        v1_d           = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        quadrant_d     = quadrant_q;

        // A load restarts the timebase and discards any sample in flight.
        if (phase_load) begin
            phase_d = phase_init;
            cnt_d   = '0;
        end else begin
            if (v1_q) begin
                sample_d       = q1_q[1] ? -rom_data_ext : rom_data_ext;
                quadrant_d     = q1_q;
                sample_valid_d = 1'b1;
            end
            if (en) begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            end
            if (tick) begin
                rom_addr_d = q_cur[0] ? (IDX_MAX - idx_cur) : idx_cur;
                q1_d       = q_cur;
                v1_d       = 1'b1;
                phase_d    = phase_q + freq_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q        <= '0;
            cnt_q          <= '0;
            rom_addr_q     <= '0;
            q1_q           <= '0;
            v1_q           <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            quadrant_q     <= '0;
        end else begin
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            rom_addr_q     <= rom_addr_d;
            q1_q           <= q1_d;
            v1_q           <= v1_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            quadrant_q     <= quadrant_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign quadrant     = quadrant_q;

endmodule
